// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button conditioning path.
// State codes are Gray-ordered so each legal transition flips a single bit.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARM_HI  = 2'b01,
    PRESSED = 2'b11,
    ARM_LO  = 2'b10
  } btn_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int SYNC_STAGES_DEF     = 2;
  localparam int CNT_W_DEF           = 20;

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Generic so that any future asynchronous input can reuse it.
module sync_ff_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Turns a bouncing button pin into a clean level plus one-cycle press/release pulses.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive stable synchronized samples.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s;
  btn_state_t       state;
  logic [CNT_W-1:0] cnt;

  sync_ff_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (btn_raw),
    .q    (s)
  );

  // The bounce check is evaluated before the terminal count, so an opposite
  // sample on the qualifying cycle still cancels the transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state <= ARM_HI;
            cnt   <= '0;
          end
        end
        ARM_HI: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= PRESSED;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!s) begin
            state <= ARM_LO;
            cnt   <= '0;
          end
        end
        ARM_LO: begin
          if (s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state         <= IDLE;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          btn_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Stimulus pushes expected pulses (kind + edge number); a monitor pops on every pulse.
module tb_button_debouncer;

  localparam int LAT = 7;  // SYNC_STAGES + DEBOUNCE_CYCLES + 1

  logic clk = 1'b0;
  logic reset;
  logic btn_raw;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;

  typedef struct {
    bit is_press;
    int cyc;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;

  bit  ds_en = 1'b0;
  int  ds_count = 0;
  int  ds_wraps = 0;
  int  ds_adv = 0;
  logic ds_prev = 1'b0;

  button_debouncer #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (press_pulse === 1'b1 || release_pulse === 1'b1) begin
      check("pulse_exclusive", int'(press_pulse & release_pulse), 0);
      if (q.size() == 0) begin
        check("unexpected_pulse", int'(press_pulse) * 2 + int'(release_pulse), 0);
      end else begin
        ev_t e;
        e = q.pop_front();
        check("pulse_kind", int'(press_pulse), int'(e.is_press));
        check("pulse_edge", cyc, e.cyc);
        check("level_at_pulse", int'(btn_level), int'(e.is_press));
      end
    end
  end

  // Downstream push/release-detect counter, modulo 10, advancing on btn_level rises.
  always @(negedge clk) begin
    if (ds_en && btn_level === 1'b1 && ds_prev === 1'b0) begin
      ds_adv++;
      if (ds_count == 9) begin
        ds_count = 0;
        ds_wraps++;
      end else begin
        ds_count++;
      end
    end
    ds_prev = btn_level;
  end

  // Drive btn_raw at a negedge and hold for n cycles; optionally expect a pulse LAT edges later.
  task automatic drive(input logic v, input int n, input int expect_kind);
    btn_raw = v;
    if (expect_kind == 1) q.push_back('{1'b1, cyc + LAT});
    if (expect_kind == 2) q.push_back('{1'b0, cyc + LAT});
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // 1. Reset with button already held.
    reset   = 1'b1;
    btn_raw = 1'b1;
    #1;
    check("rst_level", int'(btn_level), 0);
    check("rst_press", int'(press_pulse), 0);
    check("rst_release", int'(release_pulse), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    q.push_back('{1'b1, cyc + LAT});
    repeat (12) @(negedge clk);
    check("held_after_reset_level", int'(btn_level), 1);
    drive(1'b0, 12, 2);
    check("back_to_idle", int'(btn_level), 0);

    // 2. Clean press, then asynchronous reset from PRESSED.
    drive(1'b1, 12, 1);
    check("clean_press_level", int'(btn_level), 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_level", int'(btn_level), 0);
    btn_raw = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("post_reset_idle", int'(btn_level), 0);

    // 3. Bounce rejection: 3 high, 2 low, five times.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3, 0);
      drive(1'b0, 2, 0);
    end
    drive(1'b0, 10, 0);
    check("bounce_reject_level", int'(btn_level), 0);

    // 4. Release with 2-cycle glitches.
    drive(1'b1, 12, 1);
    drive(1'b0, 2, 0);
    drive(1'b1, 2, 0);
    drive(1'b0, 2, 0);
    drive(1'b1, 2, 0);
    drive(1'b0, 12, 2);
    check("bounced_release_level", int'(btn_level), 0);

    // 5. Reset while ARM_HI with cnt=2.
    drive(1'b1, 5, 0);
    reset = 1'b1;
    #1;
    check("mid_qual_reset_level", int'(btn_level), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    q.push_back('{1'b1, cyc + LAT});
    repeat (12) @(negedge clk);
    check("restart_latency_level", int'(btn_level), 1);
    drive(1'b0, 12, 2);

    // 6. Twelve bouncy press/release pairs into the downstream counter.
    ds_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1, 0);
      drive(1'b0, 1, 0);
      drive(1'b1, 2, 0);
      drive(1'b0, 1, 0);
      drive(1'b1, 10, 1);
      drive(1'b0, 1, 0);
      drive(1'b1, 1, 0);
      drive(1'b0, 10, 2);
    end
    ds_en = 1'b0;
    check("ds_advances", ds_adv, 12);
    check("ds_wraps", ds_wraps, 1);
    check("ds_final", ds_count, 2);

    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    check("outstanding_pulses", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
